// File: rtl/conv_accbin_stream.sv
// Streaming binary-conv back end: accumulates TAPS signed terms per channel and adds
// a per-channel offset. It emits one sign bit per channel per pixel, one cycle after the final tap.
module conv_accbin_stream #(
   parameter int CH   = 18,
   parameter int TAPS = 5,
   parameter int PIX  = 576,
   parameter int bW   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CH*bW-1:0]      in_data,
   input  logic                  off_we,
   input  logic [$clog2(CH)-1:0] off_addr,
   input  logic [bW-1:0]         off_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CH-1:0]         out_bits,
   output logic                  out_last,
   output logic                  err_addr
);
   localparam int ACCW = bW + $clog2(TAPS) + 1;
   localparam int SW   = ACCW + 1;
   localparam int AW   = $clog2(CH);
   localparam int TW   = $clog2(TAPS);
   localparam int PW   = (PIX > 1) ? $clog2(PIX) : 1;
   localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);
   localparam logic [PW-1:0] PIX_LAST = PW'(PIX - 1);
   localparam logic [AW:0]   CH_LIM   = (AW+1)'(CH);

   logic signed [ACCW-1:0] acc_q [CH];
   logic signed [ACCW-1:0] acc_d [CH];
   logic signed [bW-1:0]   off_q [CH];
   logic signed [bW-1:0]   off_d [CH];
   logic [TW-1:0]          tap_cnt_q, tap_cnt_d;
   logic [PW-1:0]          pix_cnt_q, pix_cnt_d;
   logic                   out_valid_q, out_valid_d;
   logic [CH-1:0]          out_bits_q, out_bits_d;
   logic                   out_last_q, out_last_d;
   logic                   err_q, err_d;

   logic                   last_tap, accept, fin;
   logic signed [bW-1:0]   term;
   logic signed [SW-1:0]   sum;

   // Only the final tap can stall, and only while a result is still unconsumed.
   assign last_tap = (tap_cnt_q == TAP_LAST);
   assign in_ready = !last_tap || !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign fin      = accept && last_tap;

   always_comb begin
      tap_cnt_d   = tap_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      out_valid_d = out_valid_q;
      out_bits_d  = out_bits_q;
      out_last_d  = out_last_q;
      err_d       = err_q;
      term        = '0;
      sum         = '0;
      for (int c = 0; c < CH; c++) begin
         acc_d[c] = acc_q[c];
         off_d[c] = off_q[c];
      end

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         tap_cnt_d = last_tap ? '0 : tap_cnt_q + TW'(1);
         for (int c = 0; c < CH; c++) begin
            term = $signed(in_data[c*bW +: bW]);
            // Tap 0 overwrites, so no separate clear cycle is needed between pixels.
            acc_d[c] = (tap_cnt_q == '0) ? ACCW'(term) : acc_q[c] + ACCW'(term);
            sum      = SW'(acc_q[c]) + SW'(term) + SW'(off_q[c]);
            if (fin) begin
               out_bits_d[c] = ~sum[SW-1];
            end
         end
      end

      if (fin) begin
         out_valid_d = 1'b1;
         out_last_d  = (pix_cnt_q == PIX_LAST);
         pix_cnt_d   = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PW'(1);
      end

      if (off_we) begin
         if ({1'b0, off_addr} >= CH_LIM) begin
            err_d = 1'b1;
         end else begin
            for (int c = 0; c < CH; c++) begin
               if (off_addr == AW'(c)) begin
                  off_d[c] = $signed(off_data);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CH; c++) begin
            acc_q[c] <= '0;
            off_q[c] <= '0;
         end
         tap_cnt_q   <= '0;
         pix_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_bits_q  <= '0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         off_q       <= off_d;
         tap_cnt_q   <= tap_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         out_valid_q <= out_valid_d;
         out_bits_q  <= out_bits_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_bits  = out_bits_q;
   assign out_last  = out_last_q;
   assign err_addr  = err_q;

endmodule
